// File: rtl/paddle_overlay.sv
//============================================================================
// Module  : paddle_overlay
// Brief   : Draws a vertically moving paddle next to the ball pixel stream,
//           moves it once per frame from two push buttons and flags a
//           ball/paddle contact once per frame.
// Config  : define PADDLE_DEBOUNCE_EN to build per-button debounce filters;
//           without it the synchronized buttons drive the paddle directly.
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module paddle_overlay #(
  parameter int PADDLE_X        = 16,
  parameter int PADDLE_W        = 8,
  parameter int PADDLE_H        = 64,
  parameter int V_ACTIVE        = 480,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_Ball,
  input  logic       i_Up,
  input  logic       i_Down,
  output logic       o_Video,
  output logic       o_Hit,
  output logic [8:0] o_PaddleY
);

  // Paddle geometry and travel limits, widened so compares and clamps never wrap.
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [8:0]  Y_RESET = 9'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0]  STEP_V  = 10'(STEP);
  localparam logic [9:0]  X_FIRST = 10'(PADDLE_X);
  localparam logic [9:0]  X_LAST  = 10'(PADDLE_X + PADDLE_W - 1);
  localparam logic [10:0] H_SPAN  = 11'(PADDLE_H);

  logic [9:0]  col_cnt;
  logic [9:0]  line_cnt;
  logic [8:0]  paddle_y;
  logic        overlap;
  logic        armed;
  logic        hit;

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]  btn_meta;
  logic [1:0]  btn_sync;
  logic [1:0]  btn_filt;

  logic        paddle_px;
  logic [10:0] y_end;
  logic [9:0]  y_ext;
  logic [9:0]  y_up;
  logic [9:0]  y_down;
  logic [9:0]  y_next;

  // Two-flop synchronizer for the asynchronous push buttons.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {i_Down, i_Up};
      btn_sync <= btn_meta;
    end
  end

`ifdef PADDLE_DEBOUNCE_EN
  localparam int            DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  for (genvar b = 0; b < 2; b++) begin : g_debounce
    logic [DB_W-1:0] db_cnt;
    logic            filt;

    // Accept a new level only after it has been seen on DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        db_cnt <= '0;
        filt   <= 1'b0;
      end else if (btn_sync[b] == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        filt   <= btn_sync[b];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign btn_filt[b] = filt;
  end
`else
  // Filter disabled: the synchronized level is used as-is.
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign btn_filt        = btn_sync;
`endif

  // Raster position: column advances through active pixels, line advances per active line.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      col_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (i_HReset) begin
        col_cnt <= '0;
      end else if (!i_HBlank) begin
        col_cnt <= col_cnt + 10'd1;
      end

      if (i_VReset) begin
        line_cnt <= '0;
      end else if (i_HReset && !i_VBlank) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // Paddle rectangle hit-test against the current raster position.
  assign y_end     = {2'b00, paddle_y} + H_SPAN;
  assign paddle_px = (col_cnt >= X_FIRST) && (col_cnt <= X_LAST) &&
                     ({1'b0, line_cnt} >= {2'b00, paddle_y}) &&
                     ({1'b0, line_cnt} < y_end);

  // Clamped candidate positions for one frame of movement.
  assign y_ext  = {1'b0, paddle_y};
  assign y_up   = (y_ext < STEP_V) ? 10'd0 : (y_ext - STEP_V);
  assign y_down = ((y_ext + STEP_V) > Y_MAX) ? Y_MAX : (y_ext + STEP_V);

  // Select the next paddle position from the filtered buttons; both or neither hold.
  always_comb begin
    y_next = y_ext;
    case (btn_filt)
      2'b01:   y_next = y_up;
      2'b10:   y_next = y_down;
      default: y_next = y_ext;
    endcase
  end

  // Per-frame state: paddle position, contact latch, and the one-clock hit report.
  // The arm bit keeps a partial frame after reset from ever reporting a hit.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      paddle_y <= Y_RESET;
      overlap  <= 1'b0;
      armed    <= 1'b0;
      hit      <= 1'b0;
    end else begin
      hit <= i_VReset & overlap & armed;
      if (i_VReset) begin
        paddle_y <= y_next[8:0];
        overlap  <= 1'b0;
        armed    <= 1'b1;
      end else if (i_Ball && paddle_px) begin
        overlap  <= 1'b1;
      end
    end
  end

  assign o_Video   = (i_Ball | paddle_px) & ~i_HBlank & ~i_VBlank;
  assign o_Hit     = hit;
  assign o_PaddleY = paddle_y;

endmodule

`default_nettype wire

// File: tb/tb_paddle_overlay.sv
//============================================================================
// Module  : tb_paddle_overlay
// Brief   : Directed, self-checking bench for paddle_overlay. A compact raster
//           generator drives short and full frames; a behavioural model keeps
//           the expected paddle row, hit pulse and pixel for every clock.
// Config  : PADDLE_DEBOUNCE_EN adds the debounce scenarios.
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_paddle_overlay;

  localparam int P_X   = 16;
  localparam int P_W   = 8;
  localparam int P_H   = 64;
  localparam int V_ACT = 480;
  localparam int STEP  = 4;
  localparam int DB    = 16;
  localparam int H_ACT = 28;
  localparam int H_BLK = 4;
  localparam int Y_TOP = V_ACT - P_H;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       hblank = 1'b1;
  logic       vblank = 1'b1;
  logic       hreset = 1'b0;
  logic       vreset = 1'b0;
  logic       ball   = 1'b0;
  logic       up     = 1'b0;
  logic       down   = 1'b0;
  logic       video;
  logic       hit;
  logic [8:0] pady;

  paddle_overlay #(
    .PADDLE_X(P_X), .PADDLE_W(P_W), .PADDLE_H(P_H),
    .V_ACTIVE(V_ACT), .STEP(STEP), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Ball(ball),
    .i_Up(up), .i_Down(down),
    .o_Video(video), .o_Hit(hit), .o_PaddleY(pady)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int m_y       = (V_ACT - P_H) / 2;
  bit m_hit     = 1'b0;
  bit m_overlap = 1'b0;
  bit m_armed   = 1'b0;
  bit eff_up    = 1'b0;
  bit eff_down  = 1'b0;
  int cur_col   = -1;
  int cur_line  = -1;
  bit chk_en    = 1'b0;
  bit ev_exp;

  // Observation counters for literal expectations.
  bit count_en   = 1'b0;
  int vid_count  = 0;
  int vid_first  = -1;
  int vid_last   = -1;
  int hit_cycles = 0;
  int first_zero = -1;

  function automatic bit pad_at(int col, int ln, int y);
    return (col >= P_X) && (col <= P_X + P_W - 1) && (ln >= y) && (ln <= y + P_H - 1);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-clock comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ev_exp = (ball || pad_at(cur_col, cur_line, m_y)) && !hblank && !vblank;
      check("video", int'(video), int'(ev_exp));
      check("hit", int'(hit), int'(m_hit));
      check("paddle_y", int'(pady), m_y);
      if (hit) hit_cycles++;
      if (count_en && video) begin
        vid_count++;
        if (vid_first < 0) vid_first = cur_line;
        vid_last = cur_line;
      end
    end
  end

  // One clock of stimulus, then the model advances by the rules for that edge.
  task automatic slot(bit hr, bit vr, bit hb, bit vb, bit b, int col, int ln);
    hreset = hr; vreset = vr; hblank = hb; vblank = vb; ball = b;
    cur_col = col; cur_line = ln;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_y = (V_ACT - P_H) / 2;
      m_overlap = 1'b0;
      m_armed = 1'b0;
      m_hit = 1'b0;
    end else begin
      m_hit = vr && m_overlap && m_armed;
      if (vr) begin
        m_overlap = 1'b0;
        m_armed = 1'b1;
        if (eff_up && !eff_down) m_y = (m_y - STEP < 0) ? 0 : m_y - STEP;
        else if (eff_down && !eff_up) m_y = (m_y + STEP > Y_TOP) ? Y_TOP : m_y + STEP;
      end else if (b && pad_at(col, ln, m_y)) begin
        m_overlap = 1'b1;
      end
    end
  endtask

  task automatic do_line(bit vr, bit vb, int ln, int ball_col);
    slot(1'b1, vr, 1'b1, vb, 1'b0, -1, -1);
    for (int i = 1; i < H_BLK; i++) slot(1'b0, 1'b0, 1'b1, vb, 1'b0, -1, -1);
    for (int p = 0; p < H_ACT; p++)
      slot(1'b0, 1'b0, 1'b0, vb, (p == ball_col), vb ? -1 : p, vb ? -1 : ln);
  endtask

  // Frame: VReset on line 0, buttons applied after line 0 for the next VReset,
  // followed by one vertical blanking line.
  task automatic do_frame(int nlines, bit f_up, bit f_down, int ball_col, int ball_line);
    for (int l = 0; l < nlines; l++) begin
      do_line(l == 0, 1'b0, l, (l == ball_line) ? ball_col : -1);
      if (l == 0) begin
        up = f_up; down = f_down; eff_up = f_up; eff_down = f_down;
      end
    end
    do_line(1'b0, 1'b1, -1, -1);
  endtask

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset; video must follow the ball even while reset is held.
    rst_n = 1'b0;
    repeat (2) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    chk_en = 1'b1;
    check("reset_y", int'(pady), 208);
    check("reset_hit", int'(hit), 0);
    slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    rst_n = 1'b1;
    repeat (2) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);

    // Full frame, no buttons: paddle drawn at lines 208-271, columns 16-23.
    count_en = 1'b1;
    do_frame(V_ACT, 1'b0, 1'b0, -1, -1);
    count_en = 1'b0;
    check("frame_y", int'(pady), 208);
    check("paddle_pixels", vid_count, 512);
    check("paddle_first_line", vid_first, 208);
    check("paddle_last_line", vid_last, 271);

    // Ball at column 20, line 220: one hit pulse at the VReset ending that frame only.
    do_frame(230, 1'b0, 1'b0, 20, 220);
    hit_cycles = 0;
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("hit_pulse_count", hit_cycles, 1);
    hit_cycles = 0;
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("no_second_hit", hit_cycles, 0);

    // Overlap in a frame, then reset mid-frame: the pending hit is discarded.
    do_line(1'b1, 1'b0, 0, -1);
    for (int l = 1; l < 225; l++) do_line(1'b0, 1'b0, l, (l == 220) ? 20 : -1);
    check("model_overlap_pending", int'(m_overlap), 1);
    rst_n = 1'b0;
    repeat (2) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    rst_n = 1'b1;
    repeat (2) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    hit_cycles = 0;
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("no_hit_after_reset", hit_cycles, 0);

    // Both buttons held: no movement.
    repeat (3) do_frame(1, 1'b1, 1'b1, -1, -1);
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("both_buttons_hold", int'(pady), 208);

    // Up held for 60 frames: reaches 0 after 52 applied frames and stays there.
    for (int j = 1; j <= 60; j++) begin
      do_frame(1, 1'b1, 1'b0, -1, -1);
      if (first_zero < 0 && pady == 9'd0) first_zero = j - 1;
    end
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("up_reach_frame", first_zero, 52);
    check("up_clamp_zero", int'(pady), 0);

    // Down from 0 to 412, then one more step to 416, then clamped.
    repeat (104) do_frame(1, 1'b0, 1'b1, -1, -1);
    check("down_412", int'(pady), 412);
    do_frame(1, 1'b0, 1'b1, -1, -1);
    check("down_416", int'(pady), 416);
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("down_clamp_416", int'(pady), 416);
    do_frame(1, 1'b0, 1'b0, -1, -1);
    check("down_still_416", int'(pady), 416);

`ifdef PADDLE_DEBOUNCE_EN
    // 10-clock glitch is rejected; a 20-clock press spanning the VReset moves the paddle.
    up = 1'b1;
    repeat (10) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    up = 1'b0;
    repeat (30) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    eff_up = 1'b0;
    slot(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
    check("db_short_pulse", int'(pady), 416);
    up = 1'b1;
    repeat (20) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    up = 1'b0;
    repeat (3) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    eff_up = 1'b1;
    slot(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
    eff_up = 1'b0;
    check("db_long_hold", int'(pady), 412);
    repeat (40) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
`endif

    repeat (4) slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
